// File: rtl/rtx_dispatch.sv
// rtx_dispatch: walks the frame raster, deals pixel jobs round-robin to NUM_LANES
// tracer lanes, parks each lane's finished pixel in a per-lane holding register and
// serialises the held results onto a single pixel stream.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start, continuous - frame start pulse (honoured in IDLE) / auto-restart level
//   lane_ready        - per-lane job acceptance
//   lane_issue        - registered one-hot job strobe with issue_h/issue_v
//   lane_done         - per-lane result strobe with lane_pixel/lane_h/lane_v slices
//   pixel_valid       - output stream strobe with pixel/pixel_h/pixel_v
//   busy, frame_done  - frame in progress / one-cycle completion pulse
//   frame_count       - completed frames (wraps)
//   err_spurious      - sticky: result strobe on a lane with no job outstanding
module rtx_dispatch #(
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned HEIGHT    = 720,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned PIX_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [NUM_LANES-1:0]         lane_ready,
  output logic [NUM_LANES-1:0]         lane_issue,
  output logic [10:0]                  issue_h,
  output logic [9:0]                   issue_v,
  input  logic [NUM_LANES-1:0]         lane_done,
  input  logic [NUM_LANES*PIX_W-1:0]   lane_pixel,
  input  logic [NUM_LANES*11-1:0]      lane_h,
  input  logic [NUM_LANES*10-1:0]      lane_v,
  output logic                         pixel_valid,
  output logic [PIX_W-1:0]             pixel,
  output logic [10:0]                  pixel_h,
  output logic [9:0]                   pixel_v,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  frame_count,
  output logic                         err_spurious
);

  localparam int unsigned HW    = 11;
  localparam int unsigned VW    = 10;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [HW-1:0]        h_q, h_d;
  logic [VW-1:0]        v_q, v_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [CNT_W-1:0]     frame_count_q, frame_count_d;
  logic [PTR_W-1:0]     issue_ptr_q, out_ptr_q;
  logic [NUM_LANES-1:0] outst_q, outst_d;
  logic [NUM_LANES-1:0] hold_vld_q, hold_vld_d;
  logic [NUM_LANES-1:0] lane_issue_q, lane_issue_d;
  logic [HW-1:0]        issue_h_q;
  logic [VW-1:0]        issue_v_q;
  logic                 pixel_valid_q;
  logic [PIX_W-1:0]     pixel_q;
  logic [HW-1:0]        pixel_h_q;
  logic [VW-1:0]        pixel_v_q;
  logic                 err_q;

  logic [PIX_W-1:0]     hold_pix_q [NUM_LANES];
  logic [HW-1:0]        hold_h_q   [NUM_LANES];
  logic [VW-1:0]        hold_v_q   [NUM_LANES];

  logic [NUM_LANES-1:0] elig, cap;
  logic                 iss_found, out_found, do_issue;
  logic [PTR_W-1:0]     iss_idx, out_idx, k;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == NUM_LANES - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Round-robin searches: first eligible lane for issue, first held result for output
  always_comb begin
    elig      = lane_ready & ~outst_q & ~hold_vld_q;
    iss_found = 1'b0;
    iss_idx   = '0;
    out_found = 1'b0;
    out_idx   = '0;
    k         = '0;
    for (int unsigned j = 0; j < NUM_LANES; j++) begin
      k = PTR_W'((32'(issue_ptr_q) + j) % NUM_LANES);
      if (!iss_found && elig[k]) begin
        iss_found = 1'b1;
        iss_idx   = k;
      end
      k = PTR_W'((32'(out_ptr_q) + j) % NUM_LANES);
      if (!out_found && hold_vld_q[k]) begin
        out_found = 1'b1;
        out_idx   = k;
      end
    end
  end

  // Frame FSM: next state, raster advance, frame bookkeeping
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    v_d           = v_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    do_issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          h_d     = '0;
          v_d     = '0;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (iss_found) begin
          do_issue = 1'b1;
          if (h_q == HW'(WIDTH - 1)) begin
            h_d = '0;
            if (v_q == VW'(HEIGHT - 1)) begin
              v_d     = '0;
              state_d = S_DRAIN;
            end else begin
              v_d = v_q + VW'(1);
            end
          end else begin
            h_d = h_q + HW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == '0 && hold_vld_q == '0) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + CNT_W'(1);
          h_d           = '0;
          v_d           = '0;
          if (continuous) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane bookkeeping: a lane is never both outstanding and holding a result
  always_comb begin
    cap          = lane_done & outst_q;
    outst_d      = outst_q & ~cap;
    lane_issue_d = '0;
    if (do_issue) begin
      outst_d[iss_idx]      = 1'b1;
      lane_issue_d[iss_idx] = 1'b1;
    end
    hold_vld_d = hold_vld_q | cap;
    if (out_found) hold_vld_d[out_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      issue_ptr_q   <= '0;
      out_ptr_q     <= '0;
      outst_q       <= '0;
      hold_vld_q    <= '0;
      lane_issue_q  <= '0;
      issue_h_q     <= '0;
      issue_v_q     <= '0;
      pixel_valid_q <= 1'b0;
      pixel_q       <= '0;
      pixel_h_q     <= '0;
      pixel_v_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      outst_q       <= outst_d;
      hold_vld_q    <= hold_vld_d;
      lane_issue_q  <= lane_issue_d;
      pixel_valid_q <= out_found;
      if (do_issue) begin
        issue_h_q   <= h_q;
        issue_v_q   <= v_q;
        issue_ptr_q <= ptr_inc(iss_idx);
      end
      if (out_found) begin
        pixel_q   <= hold_pix_q[out_idx];
        pixel_h_q <= hold_h_q[out_idx];
        pixel_v_q <= hold_v_q[out_idx];
        out_ptr_q <= ptr_inc(out_idx);
      end
      if ((lane_done & ~outst_q) != '0) err_q <= 1'b1;
    end
  end

  // Holding registers capture the lane's result together with its own coordinates
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_hold
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold_pix_q[g] <= '0;
        hold_h_q[g]   <= '0;
        hold_v_q[g]   <= '0;
      end else if (cap[g]) begin
        hold_pix_q[g] <= lane_pixel[g*PIX_W +: PIX_W];
        hold_h_q[g]   <= lane_h[g*HW +: HW];
        hold_v_q[g]   <= lane_v[g*VW +: VW];
      end
    end
  end

  assign lane_issue   = lane_issue_q;
  assign issue_h      = issue_h_q;
  assign issue_v      = issue_v_q;
  assign pixel_valid  = pixel_valid_q;
  assign pixel        = pixel_q;
  assign pixel_h      = pixel_h_q;
  assign pixel_v      = pixel_v_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_rtx_dispatch.sv
// Directed bench for rtx_dispatch on a 4x2 raster with two lanes.
module tb_rtx_dispatch;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned N  = 2;
  localparam int unsigned PW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, continuous;
  logic [N-1:0]    lane_ready, lane_issue, lane_done;
  logic [10:0]     issue_h, pixel_h;
  logic [9:0]      issue_v, pixel_v;
  logic [N*PW-1:0] lane_pixel;
  logic [N*11-1:0] lane_h;
  logic [N*10-1:0] lane_v;
  logic            pixel_valid, busy, frame_done, err_spurious;
  logic [PW-1:0]   pixel;
  logic [15:0]     frame_count;

  rtx_dispatch #(.WIDTH(W), .HEIGHT(H), .NUM_LANES(N), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .lane_ready(lane_ready), .lane_issue(lane_issue), .issue_h(issue_h), .issue_v(issue_v),
    .lane_done(lane_done), .lane_pixel(lane_pixel), .lane_h(lane_h), .lane_v(lane_v),
    .pixel_valid(pixel_valid), .pixel(pixel), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .err_spurious(err_spurious)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] pix_of(input logic [10:0] h, input logic [9:0] v);
    return 16'hA000 ^ {h[7:0], v[7:0]};
  endfunction

  // Lane model: result 3 cycles after the issue strobe
  logic auto_en = 1'b0;
  int cnt [N];
  logic [10:0] jh [N];
  logic [9:0]  jv [N];
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] = 0;
      if (auto_en) lane_done = '0;
    end else if (auto_en) begin
      for (int i = 0; i < N; i++) begin
        lane_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            lane_done[i] = 1'b1;
            lane_pixel[i*PW +: PW] = pix_of(jh[i], jv[i]);
            lane_h[i*11 +: 11] = jh[i];
            lane_v[i*10 +: 10] = jv[i];
          end
        end
        if (lane_issue[i]) begin
          cnt[i] = 3;
          jh[i]  = issue_h;
          jv[i]  = issue_v;
        end
      end
    end
  end

  // Event logs
  int cyc = 0, n_iss = 0, n_pix = 0, n_fd = 0, bad_onehot = 0;
  int          iss_lane [64];
  int          iss_cyc  [64];
  logic [10:0] iss_h    [64];
  logic [9:0]  iss_v    [64];
  int          pix_cyc  [64];
  logic [15:0] pix_val  [64];
  logic [10:0] pix_h    [64];
  logic [9:0]  pix_v    [64];
  int          fd_cyc   [8];
  always @(negedge clk) begin
    cyc++;
    if (lane_issue != '0) begin
      if ($countones(lane_issue) != 1) bad_onehot++;
      if (n_iss < 64) begin
        iss_lane[n_iss] = lane_issue[1] ? 1 : 0;
        iss_cyc[n_iss]  = cyc;
        iss_h[n_iss]    = issue_h;
        iss_v[n_iss]    = issue_v;
      end
      n_iss++;
    end
    if (pixel_valid) begin
      if (n_pix < 64) begin
        pix_cyc[n_pix] = cyc;
        pix_val[n_pix] = pixel;
        pix_h[n_pix]   = pixel_h;
        pix_v[n_pix]   = pixel_v;
      end
      n_pix++;
    end
    if (frame_done) begin
      if (n_fd < 8) fd_cyc[n_fd] = cyc;
      n_fd++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    n_iss = 0; n_pix = 0; n_fd = 0; bad_onehot = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; lane_done = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_logs();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    int b = 0;
    while (n_fd < target && b < budget) begin
      tick(1);
      b++;
    end
    tests++;
    if (n_fd < target) begin
      fails++;
      $display("FAIL %s: timeout, frame_done count %0d, wanted %0d", name, n_fd, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; lane_ready = '0; lane_done = '0;
    lane_pixel = '0; lane_h = '0; lane_v = '0;
    tick(3);
    tests++;
    if ({lane_issue, issue_h, issue_v, pixel_valid, pixel, pixel_h, pixel_v, busy,
         frame_done, frame_count, err_spurious} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: lane_issue=%b pixel_valid=%b busy=%b fc=%0d err=%b, all must be 0",
               lane_issue, pixel_valid, busy, frame_count, err_spurious);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single_frame();
    logic [7:0] seen;
    do_reset();
    auto_en = 1'b1; lane_ready = 2'b11;
    pulse_start();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b want 1", busy); end
    wait_fd(1, 300, "single_frame");
    tick(3);
    tests++;
    if (n_iss != 8) begin fails++; $display("FAIL sf_issue_count: got %0d want 8", n_iss); end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (iss_lane[k] != k % 2 || iss_h[k] !== 11'(k % 4) || iss_v[k] !== 10'(k / 4)) begin
        fails++;
        $display("FAIL sf_issue[%0d]: lane %0d (%0d,%0d) want lane %0d (%0d,%0d)",
                 k, iss_lane[k], iss_h[k], iss_v[k], k % 2, k % 4, k / 4);
      end
    end
    tests++;
    if (n_pix != 8) begin fails++; $display("FAIL sf_pixel_count: got %0d want 8", n_pix); end
    seen = '0;
    for (int k = 0; k < 8 && k < n_pix; k++) begin
      tests++;
      if (pix_val[k] !== pix_of(pix_h[k], pix_v[k]) || pix_h[k] > 3 || pix_v[k] > 1) begin
        fails++;
        $display("FAIL sf_pixel[%0d]: value %h at (%0d,%0d) want %h",
                 k, pix_val[k], pix_h[k], pix_v[k], pix_of(pix_h[k], pix_v[k]));
      end else seen[pix_v[k]*4 + pix_h[k]] = 1'b1;
    end
    tests++;
    if (seen !== 8'hFF) begin fails++; $display("FAIL sf_coverage: got %b want 11111111", seen); end
    tests++;
    if (pix_cyc[0] != iss_cyc[0] + 5) begin
      fails++; $display("FAIL sf_latency: pixel cycle %0d want %0d", pix_cyc[0], iss_cyc[0] + 5);
    end
    tests++;
    if (fd_cyc[0] != pix_cyc[7] + 1) begin
      fails++; $display("FAIL sf_done_timing: frame_done cycle %0d want %0d", fd_cyc[0], pix_cyc[7] + 1);
    end
    tests++;
    if (n_fd != 1 || frame_count !== 16'd1 || busy !== 1'b0 || bad_onehot != 0) begin
      fails++;
      $display("FAIL sf_end_state: fd=%0d fc=%0d busy=%b onehot_err=%0d want 1,1,0,0",
               n_fd, frame_count, busy, bad_onehot);
    end
  endtask

  task automatic test_simultaneous_done();
    int t;
    do_reset();
    auto_en = 1'b0; lane_ready = 2'b11;
    pulse_start();
    tick(6);
    tests++;
    if (n_iss != 2 || iss_lane[0] != 0 || iss_lane[1] != 1) begin
      fails++; $display("FAIL sim_issue: count %0d lanes %0d,%0d want 2 lanes 0,1", n_iss, iss_lane[0], iss_lane[1]);
    end
    lane_pixel = {16'h1111, 16'h2222};
    lane_h     = {11'd1, 11'd0};
    lane_v     = {10'd0, 10'd0};
    lane_done  = 2'b11;
    t = cyc;
    tick(1);
    lane_done = '0;
    tick(6);
    tests++;
    if (n_pix != 2 || pix_cyc[0] != t + 2 || pix_cyc[1] != t + 3) begin
      fails++; $display("FAIL sim_pixels: count %0d cycles %0d,%0d want 2 at %0d,%0d",
                        n_pix, pix_cyc[0], pix_cyc[1], t + 2, t + 3);
    end
    tests++;
    if (pix_val[0] !== 16'h2222 || pix_h[0] !== 11'd0 || pix_val[1] !== 16'h1111 || pix_h[1] !== 11'd1) begin
      fails++; $display("FAIL sim_order: got %h/%0d then %h/%0d want 2222/0 then 1111/1",
                        pix_val[0], pix_h[0], pix_val[1], pix_h[1]);
    end
    tests++;
    if (n_iss != 4 || iss_lane[2] != 0 || iss_cyc[2] != pix_cyc[0] + 1 ||
        iss_lane[3] != 1 || iss_cyc[3] != pix_cyc[1] + 1) begin
      fails++; $display("FAIL sim_reissue: count %0d third lane %0d @%0d fourth lane %0d @%0d want 4, 0@%0d, 1@%0d",
                        n_iss, iss_lane[2], iss_cyc[2], iss_lane[3], iss_cyc[3], pix_cyc[0] + 1, pix_cyc[1] + 1);
    end
    tests++;
    if (iss_h[2] !== 11'd2 || iss_h[3] !== 11'd3) begin
      fails++; $display("FAIL sim_reissue_coords: got %0d,%0d want 2,3", iss_h[2], iss_h[3]);
    end
  endtask

  task automatic test_lane0_not_ready();
    do_reset();
    auto_en = 1'b1; lane_ready = 2'b10;
    pulse_start();
    wait_fd(1, 400, "lane0_not_ready");
    tick(2);
    tests++;
    if (n_iss != 8) begin fails++; $display("FAIL nr_issue_count: got %0d want 8", n_iss); end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (iss_lane[k] != 1 || iss_h[k] !== 11'(k % 4) || iss_v[k] !== 10'(k / 4)) begin
        fails++; $display("FAIL nr_issue[%0d]: lane %0d (%0d,%0d) want lane 1 (%0d,%0d)",
                          k, iss_lane[k], iss_h[k], iss_v[k], k % 4, k / 4);
      end
    end
    tests++;
    if (n_pix != 8 || frame_count !== 16'd1) begin
      fails++; $display("FAIL nr_end: pixels %0d fc %0d want 8,1", n_pix, frame_count);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    auto_en = 1'b1; lane_ready = 2'b11; continuous = 1'b1;
    pulse_start();
    wait_fd(2, 600, "continuous_two");
    continuous = 1'b0;
    wait_fd(3, 400, "continuous_three");
    tick(3);
    tests++;
    if (n_fd != 3 || frame_count !== 16'd3 || busy !== 1'b0) begin
      fails++; $display("FAIL cont_end: fd %0d fc %0d busy %b want 3,3,0", n_fd, frame_count, busy);
    end
    tests++;
    if (n_iss != 24 || n_pix != 24) begin
      fails++; $display("FAIL cont_counts: issues %0d pixels %0d want 24,24", n_iss, n_pix);
    end
    for (int f = 0; f < 2; f++) begin
      tests++;
      if (iss_cyc[8*(f+1)] != fd_cyc[f] + 1 || iss_h[8*(f+1)] !== 11'd0 || iss_v[8*(f+1)] !== 10'd0) begin
        fails++; $display("FAIL cont_restart[%0d]: issue @%0d (%0d,%0d) want @%0d (0,0)",
                          f, iss_cyc[8*(f+1)], iss_h[8*(f+1)], iss_v[8*(f+1)], fd_cyc[f] + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int b = 0;
    do_reset();
    auto_en = 1'b1; lane_ready = 2'b11;
    pulse_start();
    while (n_iss < 5 && b < 200) begin tick(1); b++; end
    tests++;
    if (n_iss < 5) begin fails++; $display("FAIL mid_reach5: issues %0d want 5", n_iss); end
    rst_n = 1'b0;
    tick(1);
    tests++;
    if ({lane_issue, issue_h, issue_v, pixel_valid, pixel, pixel_h, pixel_v, busy,
         frame_done, frame_count, err_spurious} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: issue_h=%0d pixel=%h pixel_h=%0d busy=%b, all must be 0",
               issue_h, pixel, pixel_h, busy);
    end
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    pulse_start();
    wait_fd(1, 300, "rerender");
    tick(2);
    tests++;
    if (iss_h[0] !== 11'd0 || iss_v[0] !== 10'd0 || iss_lane[0] != 0) begin
      fails++; $display("FAIL mid_restart: first issue lane %0d (%0d,%0d) want lane 0 (0,0)",
                        iss_lane[0], iss_h[0], iss_v[0]);
    end
    tests++;
    if (n_pix != 8 || frame_count !== 16'd1 || err_spurious !== 1'b0) begin
      fails++; $display("FAIL mid_rerender: pixels %0d fc %0d err %b want 8,1,0", n_pix, frame_count, err_spurious);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    auto_en = 1'b0; lane_ready = 2'b11;
    tests++;
    if (err_spurious !== 1'b0) begin fails++; $display("FAIL spur_clear: got %b want 0", err_spurious); end
    lane_pixel = {16'hBEEF, 16'h0};
    lane_h     = {11'd3, 11'd0};
    lane_v     = {10'd1, 10'd0};
    lane_done  = 2'b10;
    tick(1);
    lane_done = '0;
    tick(1);
    tests++;
    if (err_spurious !== 1'b1) begin fails++; $display("FAIL spur_set: got %b want 1", err_spurious); end
    tick(5);
    tests++;
    if (err_spurious !== 1'b1 || n_pix != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL spur_sticky: err %b pixels %0d busy %b want 1,0,0", err_spurious, n_pix, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_simultaneous_done();
    test_lane0_not_ready();
    test_continuous();
    test_reset_mid_frame();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
